main_bus_arbiter: RTL and testbench

- Round-robin arbiter that shares the single main bus between NREQ bus masters (CPU cores / DMA) ahead of the paged memory controller.
- Grants one master at a time for exactly one transaction: one AddrValid cycle followed by DATAPAYLOADSIZE data beats, read or write.
- Tracks beats, enforces a one-cycle bus turnaround, times out masters that are granted but never start, and flags stray AddrValid.

---
 rtl/main_bus_arbiter_pkg.sv | 18 +
 rtl/main_bus_arbiter_rr_pick.sv | 37 +++
 rtl/main_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_main_bus_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/main_bus_arbiter_pkg.sv
// Shared definitions for the main bus arbiter and its round-robin picker.
package main_bus_arbiter_pkg;

  // Data beats carried by one main-bus transaction.
  localparam int DATAPAYLOADSIZE = 4;

  // Cycles a granted master may idle before its grant is revoked.
  localparam int ARB_TIMEOUT = 8;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_XFER,
    ARB_RELEASE
  } arb_state_t;

endpackage

// File: rtl/main_bus_arbiter_rr_pick.sv
// Round-robin picker: finds the first active request after the last owner.
module main_bus_arbiter_rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] winner
);

  localparam int IW = $clog2(NREQ);

  // Candidate index for each rotation offset 1..NREQ, wrapped modulo NREQ.
  logic [NREQ-1:0] hit;
  logic [IW-1:0]   cand [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    localparam int OFS = gi + 1;
    logic [IW:0] sum;
    assign sum       = {1'b0, last} + (IW+1)'(OFS);
    assign cand[gi]  = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : IW'(sum);
    assign hit[gi]   = req[cand[gi]];
  end

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (hit[i]) begin
        valid  = 1'b1;
        winner = cand[i];
      end
    end
  end

endmodule

// File: rtl/main_bus_arbiter.sv
// Round-robin arbiter for the shared main bus: one grant per transaction,
// beat tracking, a one-cycle turnaround, grant timeout and stray AddrValid
// detection. All outputs come straight from flops.
module main_bus_arbiter
  import main_bus_arbiter_pkg::*;
#(
  parameter int NREQ            = 2,
  parameter int DATAPAYLOADSIZE = main_bus_arbiter_pkg::DATAPAYLOADSIZE,
  parameter int TIMEOUT         = ARB_TIMEOUT
) (
  input  logic                               clk,
  input  logic                               resetL,
  input  logic [NREQ-1:0]                    req,
  input  logic                               addr_valid,
  output logic [NREQ-1:0]                    gnt,
  output logic [$clog2(NREQ)-1:0]            gnt_id,
  output logic                               bus_busy,
  output logic [$clog2(DATAPAYLOADSIZE)-1:0] beat_cnt,
  output logic                               timeout_err,
  output logic                               proto_err,
  output logic [$clog2(NREQ)-1:0]            err_id
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(DATAPAYLOADSIZE);
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_t    state_reg, state_next;
  logic [IW-1:0] owner_reg, owner_next;
  logic [IW-1:0] last_reg, last_next;
  logic [WW-1:0] wait_reg, wait_next;
  logic [BW-1:0] beat_reg, beat_next;
  logic          timeout_fire;

  logic          pick_valid;
  logic [IW-1:0] pick_id;

  logic [NREQ-1:0] gnt_next;
  logic [IW-1:0]   gnt_id_next;
  logic            busy_next;
  logic            proto_next;
  logic [IW-1:0]   err_id_next;
  logic            active_next;

  main_bus_arbiter_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req    (req),
    .last   (last_reg),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  // State register plus owner, priority pointer, wait and beat counters.
  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      state_reg <= ARB_IDLE;
      owner_reg <= '0;
      last_reg  <= IW'(NREQ - 1);
      wait_reg  <= '0;
      beat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      wait_reg  <= wait_next;
      beat_reg  <= beat_next;
    end
  end

  // Next-state logic: arbitration, address wait, burst and turnaround.
  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    last_next    = last_reg;
    wait_next    = wait_reg;
    beat_next    = beat_reg;
    timeout_fire = 1'b0;
    case (state_reg)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_next = ARB_GRANT;
          owner_next = pick_id;
          wait_next  = '0;
        end
      end
      ARB_GRANT: begin
        // addr_valid takes precedence over both withdrawal and timeout.
        if (addr_valid) begin
          state_next = ARB_XFER;
          beat_next  = '0;
        end else if (!req[owner_reg]) begin
          state_next = ARB_RELEASE;
          last_next  = owner_reg;
        end else if (wait_reg == WW'(TIMEOUT - 1)) begin
          state_next   = ARB_RELEASE;
          last_next    = owner_reg;
          timeout_fire = 1'b1;
        end else begin
          wait_next = wait_reg + WW'(1);
        end
      end
      ARB_XFER: begin
        // The burst always runs to completion regardless of req.
        if (beat_reg == BW'(DATAPAYLOADSIZE - 1)) begin
          state_next = ARB_RELEASE;
          beat_next  = '0;
          last_next  = owner_reg;
        end else begin
          beat_next = beat_reg + BW'(1);
        end
      end
      ARB_RELEASE: begin
        state_next = ARB_IDLE;
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  assign active_next = (state_next == ARB_GRANT) || (state_next == ARB_XFER);

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
    assign gnt_next[gi] = active_next && (owner_next == IW'(gi));
  end

  // Output next values: grant follows the upcoming state, errors latch an id.
  always_comb begin
    gnt_id_next = active_next ? owner_next : '0;
    busy_next   = (state_next != ARB_IDLE);
    proto_next  = addr_valid && (state_reg != ARB_GRANT);
    err_id_next = err_id;
    if (timeout_fire) begin
      err_id_next = owner_reg;
    end else if (proto_next) begin
      err_id_next = gnt_id;
    end
  end

  // Registered outputs; reset clears them immediately with no error pulse.
  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      gnt         <= '0;
      gnt_id      <= '0;
      bus_busy    <= 1'b0;
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
      err_id      <= '0;
    end else begin
      gnt         <= gnt_next;
      gnt_id      <= gnt_id_next;
      bus_busy    <= busy_next;
      timeout_err <= timeout_fire;
      proto_err   <= proto_next;
      err_id      <= err_id_next;
    end
  end

  assign beat_cnt = beat_reg;

endmodule

// File: tb/tb_main_bus_arbiter.sv
// Directed bench for main_bus_arbiter (NREQ=2, 4 beats, timeout 8).
module tb_main_bus_arbiter;

  logic       clk = 1'b0;
  logic       resetL = 1'b0;
  logic [1:0] req = 2'b00;
  logic       addr_valid = 1'b0;
  logic [1:0] gnt;
  logic       gnt_id;
  logic       bus_busy;
  logic [1:0] beat_cnt;
  logic       timeout_err;
  logic       proto_err;
  logic       err_id;

  int checks = 0;
  int errors = 0;

  main_bus_arbiter #(
    .NREQ            (2),
    .DATAPAYLOADSIZE (4),
    .TIMEOUT         (8)
  ) dut (
    .clk         (clk),
    .resetL      (resetL),
    .req         (req),
    .addr_valid  (addr_valid),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .bus_busy    (bus_busy),
    .beat_cnt    (beat_cnt),
    .timeout_err (timeout_err),
    .proto_err   (proto_err),
    .err_id      (err_id)
  );

  always #5 clk = ~clk;

  // Observed output bundle: {gnt, gnt_id, bus_busy, beat_cnt, timeout_err, proto_err, err_id}
  logic [8:0] obs;
  assign obs = {gnt, gnt_id, bus_busy, beat_cnt, timeout_err, proto_err, err_id};

  typedef struct {
    logic [1:0] req;
    logic       av;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [1:0] r, input logic a,
                              input logic [1:0] g, input logic id, input logic busy,
                              input logic [1:0] beat, input logic to, input logic pe,
                              input logic eid);
    vec_t v;
    v.req = r;
    v.av  = a;
    v.exp = {g, id, busy, beat, to, pe, eid};
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (gnt,id,busy,beat,to,pe,eid)", name, act, exp);
    end
  endtask

  task automatic wait_grant(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (gnt != 2'b00) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: no grant within 40 cycles, got gnt=%b required nonzero", name, gnt);
    end
  endtask

  task automatic wait_release(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (gnt == 2'b00) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: grant never dropped, got gnt=%b required 00", name, gnt);
    end
  endtask

  initial begin
    // Cycle-by-cycle script: inputs for a cycle, outputs expected after its edge.
    // Single master transaction.
    add(2'b01, 0, 2'b01, 0, 1, 0, 0, 0, 0);
    add(2'b01, 1, 2'b01, 0, 1, 0, 0, 0, 0);
    add(2'b01, 0, 2'b01, 0, 1, 1, 0, 0, 0);
    add(2'b01, 0, 2'b01, 0, 1, 2, 0, 0, 0);
    add(2'b01, 0, 2'b01, 0, 1, 3, 0, 0, 0);
    add(2'b01, 0, 2'b00, 0, 1, 0, 0, 0, 0);
    add(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    // Stray addr_valid in IDLE.
    add(2'b00, 1, 2'b00, 0, 0, 0, 0, 1, 0);
    add(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    // Master 1 transaction with a stray addr_valid in XFER, then in RELEASE.
    add(2'b10, 0, 2'b10, 1, 1, 0, 0, 0, 0);
    add(2'b10, 1, 2'b10, 1, 1, 0, 0, 0, 0);
    add(2'b10, 1, 2'b10, 1, 1, 1, 0, 1, 1);
    add(2'b10, 0, 2'b10, 1, 1, 2, 0, 0, 1);
    add(2'b10, 0, 2'b10, 1, 1, 3, 0, 0, 1);
    add(2'b00, 0, 2'b00, 0, 1, 0, 0, 0, 1);
    add(2'b00, 1, 2'b00, 0, 0, 0, 0, 1, 0);
    add(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    // Timeout of master 1; master 0 requesting meanwhile gets the next grant.
    add(2'b10, 0, 2'b10, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) add(2'b11, 0, 2'b10, 1, 1, 0, 0, 0, 0);
    add(2'b11, 0, 2'b00, 0, 1, 0, 1, 0, 1);
    add(2'b11, 0, 2'b00, 0, 0, 0, 0, 0, 1);
    add(2'b11, 0, 2'b01, 0, 1, 0, 0, 0, 1);
    // Master 0 withdraws in GRANT.
    add(2'b00, 0, 2'b00, 0, 1, 0, 0, 0, 1);
    add(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 1);
    // Master 0 drops req during beat 1; burst still completes.
    add(2'b01, 0, 2'b01, 0, 1, 0, 0, 0, 1);
    add(2'b01, 1, 2'b01, 0, 1, 0, 0, 0, 1);
    add(2'b01, 0, 2'b01, 0, 1, 1, 0, 0, 1);
    add(2'b00, 0, 2'b01, 0, 1, 2, 0, 0, 1);
    add(2'b00, 0, 2'b01, 0, 1, 3, 0, 0, 1);
    add(2'b00, 0, 2'b00, 0, 1, 0, 0, 0, 1);
    add(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 1);
    // addr_valid arrives in the last GRANT cycle: it beats the timeout.
    add(2'b01, 0, 2'b01, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) add(2'b01, 0, 2'b01, 0, 1, 0, 0, 0, 1);
    add(2'b01, 1, 2'b01, 0, 1, 0, 0, 0, 1);
    add(2'b01, 0, 2'b01, 0, 1, 1, 0, 0, 1);
    add(2'b01, 0, 2'b01, 0, 1, 2, 0, 0, 1);
    add(2'b00, 0, 2'b01, 0, 1, 3, 0, 0, 1);
    add(2'b00, 0, 2'b00, 0, 1, 0, 0, 0, 1);
    add(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 1);

    // Reset state.
    tick();
    tick();
    check("reset_state", obs, 9'd0);
    resetL = 1'b1;
    tick();

    foreach (vecs[i]) begin
      req        = vecs[i].req;
      addr_valid = vecs[i].av;
      tick();
      check($sformatf("vec%0d", i), obs, vecs[i].exp);
      $display("vec %0d: req=%b av=%b -> gnt=%b id=%0d busy=%b beat=%0d to=%b pe=%b eid=%0d",
               i, vecs[i].req, vecs[i].av, gnt, gnt_id, bus_busy, beat_cnt,
               timeout_err, proto_err, err_id);
    end
    addr_valid = 1'b0;
    req        = 2'b00;

    // Contention: both masters request from reset; grants alternate 01,10,01,10.
    resetL = 1'b0;
    req    = 2'b11;
    tick();
    tick();
    resetL = 1'b1;
    tick();
    check("cont_first_latency", {7'd0, gnt}, 9'b01);
    for (int k = 0; k < 4; k++) begin
      logic [1:0] exp_g;
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      wait_grant("cont_wait_grant");
      check($sformatf("cont_grant%0d", k), {7'd0, gnt}, {7'd0, exp_g});
      $display("contention grant %0d: gnt=%b", k, gnt);
      addr_valid = 1'b1;
      tick();
      addr_valid = 1'b0;
      if (k < 3) wait_release("cont_wait_release");
    end

    // Master 1 now in XFER with master 0 as the pointer; reset mid-burst.
    tick();
    #2;
    resetL = 1'b0;
    #1;
    check("reset_async", obs, 9'd0);
    $display("async reset mid-XFER: obs=%b", obs);
    tick();
    resetL = 1'b1;
    tick();
    check("reset_first_grant", {7'd0, gnt}, 9'b01);
    $display("first grant after reset: gnt=%b", gnt);
    req = 2'b00;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
